// File: rtl/add_pipe_seg.sv
// Pipelined adder/subtractor: WIDTH bits resolved SEG bits per stage, carry registered between stages.
// Upper operand segments ride along with each transaction; finished low segments accumulate up to the output.
module add_pipe_seg #(
    parameter int WIDTH = 48,
    parameter int SEG   = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data_one,
    input  logic [WIDTH-1:0] i_data_two,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_carry,
    output logic             o_overflow
);
    localparam int STAGES = (SEG >= 1) ? (WIDTH / SEG) : 1;

    if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_params
        $error("add_pipe_seg: WIDTH must be a positive multiple of SEG");
    end

    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // The whole pipeline advances together; it only freezes when the output is full and not taken.
    logic             en;
    logic [WIDTH-1:0] b_in;
    logic             cin0;

    assign en      = ~o_valid | i_ready;
    assign o_ready = en;
    assign b_in    = i_sub ? ~i_data_two : i_data_two;
    assign cin0    = i_sub ? ~i_carry : i_carry;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic                 valid_q;
        logic                 carry_q;
        logic [(k+1)*SEG-1:0] sum_q;
        logic [(k+1)*SEG-1:0] sum_d;
        logic [SEG-1:0]       seg_a;
        logic [SEG-1:0]       seg_b;
        logic                 seg_cin;
        logic                 seg_vin;
        logic [SEG:0]         seg_sum;

        if (k == 0) begin : g_src
            assign seg_a   = i_data_one[SEG-1:0];
            assign seg_b   = b_in[SEG-1:0];
            assign seg_cin = cin0;
            assign seg_vin = i_valid;
            assign sum_d   = seg_sum[SEG-1:0];
        end else begin : g_src
            assign seg_a   = g_stg[k-1].g_op.a_q[SEG-1:0];
            assign seg_b   = g_stg[k-1].g_op.b_q[SEG-1:0];
            assign seg_cin = g_stg[k-1].carry_q;
            assign seg_vin = g_stg[k-1].valid_q;
            assign sum_d   = {seg_sum[SEG-1:0], g_stg[k-1].sum_q};
        end

        assign seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, seg_cin};

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (en) begin
                valid_q <= seg_vin;
                carry_q <= seg_sum[SEG];
                sum_q   <= sum_d;
            end
        end

        // Operand bits not yet consumed, shifted so the next segment sits at bit 0.
        if (k < STAGES - 1) begin : g_op
            localparam int REM = WIDTH - (k + 1) * SEG;
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;
            logic [REM-1:0] a_d;
            logic [REM-1:0] b_d;

            if (k == 0) begin : g_in
                assign a_d = i_data_one[WIDTH-1:SEG];
                assign b_d = b_in[WIDTH-1:SEG];
            end else begin : g_in
                assign a_d = g_stg[k-1].g_op.a_q[REM+SEG-1:SEG];
                assign b_d = g_stg[k-1].g_op.b_q[REM+SEG-1:SEG];
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic msb_cin;
            logic ovf_q;

            // Carry into the MSB recovered from its sum bit; with SEG == 1 this is the stage carry-in.
            assign msb_cin = seg_a[SEG-1] ^ seg_b[SEG-1] ^ seg_sum[SEG-1];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= msb_cin ^ seg_sum[SEG];
                end
            end
        end
    end

    assign o_valid    = g_stg[STAGES-1].valid_q;
    assign o_data     = g_stg[STAGES-1].sum_q;
    assign o_carry    = g_stg[STAGES-1].carry_q;
    assign o_overflow = g_stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_add_pipe_seg.sv
// Directed bench for add_pipe_seg: hand-computed vectors plus a scoreboard of accepted operations.
module tb_add_pipe_seg;
    localparam int WIDTH  = 48;
    localparam int SEG    = 12;
    localparam int STAGES = WIDTH / SEG;
    localparam int RW     = WIDTH + 2;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data_one;
    logic [WIDTH-1:0] i_data_two;
    logic             i_carry;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_carry;
    logic             o_overflow;

    always #5 i_clk = ~i_clk;

    add_pipe_seg #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data_one (i_data_one),
        .i_data_two (i_data_two),
        .i_carry    (i_carry),
        .i_sub      (i_sub),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_carry    (o_carry),
        .o_overflow (o_overflow)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboard entries are {carry, overflow, data}.
    logic [RW-1:0]    exp_q[$];
    int               cyc        = 0;
    int               accepted   = 0;
    int               produced   = 0;
    int               acc_cyc    = 0;
    int               res_cyc    = 0;
    logic             got_result = 1'b0;
    logic [WIDTH-1:0] res_data   = '0;
    logic             res_carry  = 1'b0;
    logic             res_ovf    = 1'b0;
    logic             prev_stall = 1'b0;
    logic [RW-1:0]    prev_out   = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic cin, input logic sub);
        logic [WIDTH-1:0] bb;
        logic             c0;
        logic [WIDTH:0]   full;
        logic             ov;
        bb   = sub ? ~b : b;
        c0   = sub ? ~cin : cin;
        full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c0};
        ov   = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return {full[WIDTH], ov, full[WIDTH-1:0]};
    endfunction

    // One clock cycle: sample at the falling edge, score handshakes, then advance past the rising edge.
    task automatic tick();
        logic [RW-1:0] e;
        @(negedge i_clk);
        got_result = 1'b0;
        if (o_valid && i_ready) begin
            got_result = 1'b1;
            res_cyc    = cyc;
            res_data   = o_data;
            res_carry  = o_carry;
            res_ovf    = o_overflow;
            produced++;
            if (exp_q.size() == 0) begin
                check("spurious_result", 64'(o_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("res_data", 64'(o_data), 64'(e[WIDTH-1:0]));
                check("res_ovf", 64'(o_overflow), 64'(e[WIDTH]));
                check("res_carry", 64'(o_carry), 64'(e[WIDTH+1]));
            end
        end
        if (o_valid && !i_ready) begin
            check("ready_low_stall", 64'(o_ready), 64'd0);
            if (prev_stall) check("stall_hold", 64'({o_carry, o_overflow, o_data}), 64'(prev_out));
        end
        prev_stall = o_valid && !i_ready;
        prev_out   = {o_carry, o_overflow, o_data};
        if (i_valid && o_ready && !i_rst) begin
            exp_q.push_back(model(i_data_one, i_data_two, i_carry, i_sub));
            acc_cyc = cyc;
            accepted++;
        end
        cyc++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub, input logic [WIDTH-1:0] exp_d,
                            input logic exp_c, input logic exp_o);
        int n;
        i_valid    = 1'b1;
        i_data_one = a;
        i_data_two = b;
        i_carry    = cin;
        i_sub      = sub;
        i_ready    = 1'b1;
        check({tag, "_ready"}, 64'(o_ready), 64'd1);
        tick();
        i_valid = 1'b0;
        n = 0;
        got_result = 1'b0;
        while (!got_result && n < 12) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, 64'(got_result), 64'd1);
        check({tag, "_latency"}, 64'(res_cyc - acc_cyc), 64'(STAGES));
        check({tag, "_data"}, 64'(res_data), 64'(exp_d));
        check({tag, "_carry"}, 64'(res_carry), 64'(exp_c));
        check({tag, "_ovf"}, 64'(res_ovf), 64'(exp_o));
    endtask

    initial begin
        int p_acc;
        int p_prod;
        int first_after;
        int last_after;
        int cnt_after;

        i_rst      = 1'b1;
        i_valid    = 1'b0;
        i_data_one = '0;
        i_data_two = '0;
        i_carry    = 1'b0;
        i_sub      = 1'b0;
        i_ready    = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_carry", 64'(o_carry), 64'd0);
        check("rst_ovf", 64'(o_overflow), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);

        directed("ripple", 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, 1'b0, 48'h0, 1'b1, 1'b0);
        directed("sub_borrow", 48'd5, 48'd7, 1'b1, 1'b1, 48'hFFFF_FFFF_FFFD, 1'b0, 1'b0);
        directed("sub_plain", 48'd7, 48'd5, 1'b0, 1'b1, 48'd2, 1'b1, 1'b0);
        directed("ovf_add", 48'h7FFF_FFFF_FFFF, 48'd1, 1'b0, 1'b0, 48'h8000_0000_0000, 1'b0, 1'b1);
        directed("ovf_sub", 48'h8000_0000_0000, 48'd1, 1'b0, 1'b1, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b1);
        directed("mixed_add", 48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 1'b1, 1'b0,
                 48'h2222_2222_2222, 1'b0, 1'b0);

        // Ten back-to-back operations with the consumer stalled for cycles 6..15.
        p_acc       = accepted;
        p_prod      = produced;
        first_after = -1;
        last_after  = -1;
        cnt_after   = 0;
        for (int n = 0; n < 60 && (produced - p_prod) < 10; n++) begin
            i_valid    = (accepted - p_acc) < 10;
            i_data_one = WIDTH'({$urandom(), $urandom()});
            i_data_two = WIDTH'({$urandom(), $urandom()});
            i_carry    = 1'($urandom_range(0, 1));
            i_sub      = 1'($urandom_range(0, 1));
            i_ready    = !(n >= 6 && n <= 15);
            tick();
            if (got_result && n > 15) begin
                if (first_after < 0) first_after = res_cyc;
                last_after = res_cyc;
                cnt_after++;
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("bp_accepted", 64'(accepted - p_acc), 64'd10);
        check("bp_produced", 64'(produced - p_prod), 64'd10);
        check("bp_no_gaps", 64'(last_after - first_after), 64'(cnt_after - 1));

        // Alternating bubbles with a consumer that toggles every cycle, then drain.
        p_acc  = accepted;
        p_prod = produced;
        for (int n = 0; n < 24; n++) begin
            i_valid    = (n % 2) == 0;
            i_ready    = (n % 2) == 1;
            i_data_one = WIDTH'({$urandom(), $urandom()});
            i_data_two = WIDTH'({$urandom(), $urandom()});
            i_carry    = 1'($urandom_range(0, 1));
            i_sub      = 1'($urandom_range(0, 1));
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) tick();
        check("bubble_count", 64'(produced - p_prod), 64'(accepted - p_acc));
        check("bubble_drained", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of three accepted operations discards all of them.
        for (int n = 0; n < 3; n++) begin
            i_valid    = 1'b1;
            i_data_one = WIDTH'(n + 100);
            i_data_two = WIDTH'(n + 3);
            i_carry    = 1'b0;
            i_sub      = 1'b0;
            i_rst      = (n == 2);
            tick();
        end
        i_rst   = 1'b0;
        i_valid = 1'b0;
        exp_q.delete();
        prev_stall = 1'b0;
        check("flush_valid", 64'(o_valid), 64'd0);
        check("flush_ready", 64'(o_ready), 64'd1);
        check("flush_data", 64'(o_data), 64'd0);
        for (int n = 0; n < 8; n++) begin
            tick();
            check("flush_quiet", 64'(o_valid), 64'd0);
        end
        directed("post_rst", 48'h0000_0000_00FF, 48'h0000_0000_0F01, 1'b1, 1'b0,
                 48'h0000_0000_1001, 1'b0, 1'b0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
